// File: rtl/bcd_converter_if.sv
// Handshake and result bundle between the divider-side controller and the BCD converter.
// The master issues conversions; the slave (converter) returns digits and a blank mask.
interface bcd_converter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (output start, value, input  busy, done, bcd, blank);
    modport slave  (input  start, value, output busy, done, bcd, blank);
endinterface

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// leading-zero blank mask for the seven-segment driver.
module bcd_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic           clk,
    input  logic           reset,
    bcd_converter_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
        $error("bcd_converter: DIGITS too small to hold 2^WIDTH-1");
    end

    // A digit is blank while it and every digit above it are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] r;
        logic              lead;
        r    = '0;
        lead = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            lead = lead && (d[4*i +: 4] == 4'd0);
            r[i] = lead;
        end
        return r;
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [4*DIGITS-1:0]   scratch;
    logic [WIDTH-1:0]      binary;
    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   scratch_next;
    logic [WIDTH-1:0]      binary_next;

    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        {scratch_next, binary_next} = {adjusted, binary} << 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            scratch   <= '0;
            binary    <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.bcd   <= '0;
            bus.blank <= BLANK_RESET;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        binary   <= bus.value;
                        scratch  <= '0;
                        count    <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    scratch <= scratch_next;
                    binary  <= binary_next;
                    count   <= count - CW'(1);
                    // The last shift's result goes straight to the outputs on the same edge.
                    if (count == CW'(1)) begin
                        bus.bcd   <= scratch_next;
                        bus.blank <= blank_of(scratch_next);
                        bus.done  <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: a cycle-level acceptance model pushes expected
// results computed with decimal arithmetic; a monitor pops and compares on each done.
module tb_bcd_converter;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = WIDTH;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   blank;
        int                  cyc;
    } exp_t;

    logic clk;
    logic reset;
    bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   cyc         = 0;
    int   next_accept = 0;
    int   n_checks    = 0;
    int   n_fail      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_blank(input int v);
        logic [DIGITS-1:0] r;
        int p;
        r = '0;
        p = 10;
        for (int d = 1; d < DIGITS; d++) begin
            r[d] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    // Acceptance model: a start is taken on any edge at least LAT+1 after the previous one.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            cyc++;
            if (!reset) begin
                q.delete();
                next_accept = 0;
            end else if (bus.start && cyc >= next_accept) begin
                e.bcd   = ref_bcd(int'(bus.value));
                e.blank = ref_blank(int'(bus.value));
                e.cyc   = cyc + LAT;
                q.push_back(e);
                next_accept = cyc + LAT + 1;
            end
        end
    end

    // Monitor: busy every cycle, and a scoreboard pop on every done.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            check("busy", 32'(bus.busy), 32'(cyc < next_accept - 1));
            if (bus.done) begin
                if (prev_done) check("done_consecutive", 32'(1), 32'(0));
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("bcd", 32'(bus.bcd), 32'(e.bcd));
                    check("blank", 32'(bus.blank), 32'(e.blank));
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic run_one(input int v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 16'(v);
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = 16'($urandom);
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"},   32'(bus.bcd),   32'h0);
        check({tag, "_blank"}, 32'(bus.blank), 32'b11110);
        check({tag, "_busy"},  32'(bus.busy),  32'h0);
        check({tag, "_done"},  32'(bus.done),  32'h0);
    endtask

    initial begin
        int directed[7] = '{9, 3, 1, 3, 0, 65535, 1000};
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        foreach (directed[i]) run_one(directed[i]);

        // Start pulse during a conversion must be ignored, not queued.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 16'd1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.value = 16'd42;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Start held high: back-to-back conversions, value changed mid-run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 16'd1234;
        @(negedge clk);
        bus.value = 16'd8;
        repeat (LAT + 1) @(negedge clk);
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Reset mid-conversion.
        run_one(12345);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 16'd777;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        check_reset_outputs("abort_hold");
        reset = 1'b1;
        run_one(777);

        for (int i = 0; i < 20; i++) run_one(int'($urandom_range(0, 65535)));

        repeat (LAT + 4) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 16-bit divider. It takes a divider result (quotient or remainder) on a start pulse and produces packed decimal digits plus a leading-zero blank mask for the seven-segment display driver. It uses shift-and-add-3 (double dabble) with one bit processed per clock, so it contains no wide combinational arithmetic.

## Interface
- WIDTH, default 16: binary input width; must match the divider output width.
- DIGITS, default 5: number of BCD digits. Must satisfy 10^DIGITS > 2^WIDTH − 1, so overflow cannot occur. Elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. One clock domain.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  binary operand, typically the divider quotient or remainder; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd and blank are updated on the same edge.
- bcd  output  4*DIGITS  packed result; digit 0 (ones) in bits [3:0].
- blank  output  DIGITS  bit i high when digit i is a leading zero. Bit 0 is always 0.

## Operation
- States: IDLE, RUN.
- IDLE with start=1:
  - capture value into the binary shift register;
  - clear the BCD scratch register;
  - load the bit counter with WIDTH;
  - go to RUN and set busy=1.
- IDLE with start=0: hold; outputs keep their last values.
- RUN, each cycle:
  - every scratch digit ≥ 5 gets +3, all digits in parallel;
  - then the concatenation {scratch, binary} shifts left by 1;
  - the counter decrements.
- RUN with counter = 1 (last shift):
  - write the final scratch value to bcd;
  - compute blank from it;
  - pulse done=1, clear busy;
  - return to IDLE.
- blank rule: scan from the most significant digit downward; a digit is blank while it and every higher digit are zero. Digit 0 is never blanked.
- start is ignored while in RUN, including on the done edge. value changes during RUN have no effect.
- The scratch register holds 4*DIGITS bits. The add-3 step applies to every digit on every iteration.
- bcd and blank hold their values until the next done. They are not cleared when a new conversion starts.

## Timing
- Reset (asynchronous assert, deassert synchronous to clk):
  - state = IDLE, busy = 0, done = 0;
  - bcd = 0;
  - blank = all digits except digit 0 set, i.e. 5'b11110 for DIGITS=5;
  - counter and scratch = 0.
- Reset asserted mid-conversion aborts it immediately. No done pulse is produced, and bcd returns to 0.
- Latency:
  - start is accepted on edge N;
  - busy is high from edge N to edge N+WIDTH;
  - done is high for exactly the cycle after edge N+WIDTH (16 cycles for WIDTH=16).
- Throughput:
  - earliest next acceptance is edge N+WIDTH+1;
  - with start held high, one result every WIDTH+1 cycles.
- done never asserts for two consecutive cycles.

## Test plan
- Reset then idle:
  - check bcd=0x00000, blank=5'b11110, busy=0, done=0;
  - start=1, value=9 → done after exactly 16 cycles, bcd=0x00009, blank=5'b11110.
- Divider outputs in sequence:
  - value=3 (6/2 quotient) → bcd=0x00003;
  - value=1 (8/5 quotient) → bcd=0x00001;
  - value=3 (8/5 remainder) → bcd=0x00003;
  - each with blank=5'b11110.
- Extremes:
  - value=0 → bcd=0x00000, blank=5'b11110;
  - value=65535 → bcd=0x65535, blank=5'b00000;
  - value=1000 → bcd=0x01000, blank=5'b10000.
- Start during busy:
  - start value=1234, then pulse start with value=42 at cycle 5 → a single done, bcd=0x01234;
  - the start=42 pulse is not queued.
- Back-to-back:
  - start held high, value=1234 then 8 → done pulses 17 cycles apart;
  - bcd=0x01234, then 0x00008;
  - busy is low for exactly one cycle between conversions.
- Reset mid-operation:
  - convert 12345, confirm bcd=0x12345;
  - start 777 and assert reset at cycle 8 → no done pulse, bcd=0, blank=5'b11110;
  - after release, a fresh start with 777 → bcd=0x00777.
